// File: rtl/alu_instr_enc_if.sv
// Request/response bundle for the ALU instruction encoder.
// The slave side is the encoder; the master side drives requests and drains the FIFO.
interface alu_instr_enc_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  alucontrol;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;
    logic [15:0] enc_count;
    logic [7:0]  err_count;

    modport slave (
        input  in_valid, alucontrol, rs, rt, rd, sa, imm, out_ready,
        output in_ready, out_valid, instr, err, enc_count, err_count
    );

    modport master (
        output in_valid, alucontrol, rs, rt, rd, sa, imm, out_ready,
        input  in_ready, out_valid, instr, err, enc_count, err_count
    );
endinterface

// File: rtl/alu_instr_enc.sv
// Inverse of the ALU decoder: turns an alucontrol code plus fields into a MIPS word,
// buffered in a 2-entry FIFO with push/error counters.
module alu_instr_enc (
    input  logic            clk,
    input  logic            rst,
    alu_instr_enc_if.slave  bus
);
    localparam logic [4:0] ALU_DONOTHING = 5'd0;
    localparam logic [4:0] ALU_AND       = 5'd1;
    localparam logic [4:0] ALU_OR        = 5'd2;
    localparam logic [4:0] ALU_XOR       = 5'd3;
    localparam logic [4:0] ALU_NOR       = 5'd4;
    localparam logic [4:0] ALU_SLL       = 5'd5;
    localparam logic [4:0] ALU_SRL       = 5'd6;
    localparam logic [4:0] ALU_SRA       = 5'd7;
    localparam logic [4:0] ALU_SLLV      = 5'd8;
    localparam logic [4:0] ALU_SRLV      = 5'd9;
    localparam logic [4:0] ALU_SRAV      = 5'd10;
    localparam logic [4:0] ALU_ANDI      = 5'd11;
    localparam logic [4:0] ALU_ORI       = 5'd12;
    localparam logic [4:0] ALU_XORI      = 5'd13;
    localparam logic [4:0] ALU_LUI       = 5'd14;

    logic [31:0] enc_instr;
    logic        enc_err;

    logic [1:0]  count;
    logic        wptr;
    logic        rptr;
    logic [31:0] mem_instr [2];
    logic        mem_err   [2];
    logic [15:0] enc_count;
    logic [7:0]  err_count;
    logic        push;
    logic        pop;

    always_comb begin
        enc_instr = 32'h0000_0000;
        enc_err   = 1'b0;
        case (bus.alucontrol)
            ALU_AND:  enc_instr = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, 6'b100100};
            ALU_OR:   enc_instr = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, 6'b100101};
            ALU_XOR:  enc_instr = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, 6'b100110};
            ALU_NOR:  enc_instr = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, 6'b100111};
            ALU_SLL:  enc_instr = {6'b000000, 5'b0, bus.rt, bus.rd, bus.sa, 6'b000000};
            ALU_SRL:  enc_instr = {6'b000000, 5'b0, bus.rt, bus.rd, bus.sa, 6'b000010};
            ALU_SRA:  enc_instr = {6'b000000, 5'b0, bus.rt, bus.rd, bus.sa, 6'b000011};
            ALU_SLLV: enc_instr = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, 6'b000100};
            ALU_SRLV: enc_instr = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, 6'b000110};
            ALU_SRAV: enc_instr = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b0, 6'b000111};
            ALU_ANDI: enc_instr = {6'b001100, bus.rs, bus.rt, bus.imm};
            ALU_ORI:  enc_instr = {6'b001101, bus.rs, bus.rt, bus.imm};
            ALU_XORI: enc_instr = {6'b001110, bus.rs, bus.rt, bus.imm};
            // LUI has no source register; rs is deliberately dropped
            ALU_LUI:  enc_instr = {6'b001111, 5'b0, bus.rt, bus.imm};
            default: begin
                enc_instr = 32'h0000_0000;
                enc_err   = 1'b1;
            end
        endcase
    end

    // Handshake status depends only on registered occupancy
    assign bus.in_ready  = (count < 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign bus.instr     = bus.out_valid ? mem_instr[rptr] : 32'h0000_0000;
    assign bus.err       = bus.out_valid ? mem_err[rptr]   : 1'b0;
    assign bus.enc_count = enc_count;
    assign bus.err_count = err_count;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= 2'd0;
            wptr         <= 1'b0;
            rptr         <= 1'b0;
            enc_count    <= 16'd0;
            err_count    <= 8'd0;
            mem_instr[0] <= 32'h0000_0000;
            mem_instr[1] <= 32'h0000_0000;
            mem_err[0]   <= 1'b0;
            mem_err[1]   <= 1'b0;
        end else begin
            if (push) begin
                mem_instr[wptr] <= enc_instr;
                mem_err[wptr]   <= enc_err;
                wptr            <= ~wptr;
                enc_count       <= enc_count + 16'd1;
                if (enc_err && (err_count != 8'hFF))
                    err_count <= err_count + 8'd1;
            end
            if (pop)
                rptr <= ~rptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: doc/alu_instr_enc.md
ALU_INSTR_ENC -- requirements
Module: alu_instr_enc

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 in_valid  input  1  request carries an operation to encode.
REQ-004 in_ready  output  1  block can accept a request this cycle.
REQ-005 alucontrol  input  5  operation, uses the `ALU_*` codes from aludefines.vh.
REQ-006 rs, rt, rd, sa  input  5 each  register and shift-amount fields.
REQ-007 imm  input  16  immediate field.
REQ-008 out_valid  output  1  instr/err at the FIFO head are valid.
REQ-009 out_ready  input  1  consumer accepts the head entry.
REQ-010 instr  output  32  encoded MIPS instruction word.
REQ-011 err  output  1  head entry came from an unsupported alucontrol.
REQ-012 enc_count  output  16  total entries pushed, wraps 0xFFFF->0x0000.
REQ-013 err_count  output  8  total error entries pushed, saturates at 0xFF.

Function
REQ-014 The block SHALL be the inverse of the ALU decoder: for each supported alucontrol it SHALL produce a word that decodes back to the same alucontrol.
REQ-015 R-type codes SHALL encode as {6'b000000, rs, rt, rd, 5'b0, funct}: `ALU_AND` funct 100100, `ALU_OR` 100101, `ALU_XOR` 100110, `ALU_NOR` 100111.
REQ-016 Shift-by-immediate codes SHALL encode as {6'b0, 5'b0, rt, rd, sa, funct}: `ALU_SLL` 000000, `ALU_SRL` 000010, `ALU_SRA` 000011.
REQ-017 Variable shift codes SHALL encode as {6'b0, rs, rt, rd, 5'b0, funct}: `ALU_SLLV` 000100, `ALU_SRLV` 000110, `ALU_SRAV` 000111.
REQ-018 I-type codes SHALL encode as {op, rs, rt, imm}: `ALU_ANDI` op 001100, `ALU_ORI` 001101, `ALU_XORI` 001110.
REQ-019 `ALU_LUI` SHALL encode as {6'b001111, 5'b0, rt, imm}, and it SHALL ignore rs.
REQ-020 Any other alucontrol value, including `ALU_DONOTHING`, SHALL push instr=32'h0000_0000 with err=1.
REQ-021 The encoded word SHALL be pushed into a 2-entry FIFO; a push occurs when in_valid && in_ready.
REQ-022 in_ready SHALL be 1 exactly when FIFO occupancy < 2. It is combinational from registered occupancy only and SHALL NOT depend on in_valid or out_ready.
REQ-023 Latency: a request accepted at edge N SHALL appear at the head with out_valid=1 in cycle N+1 when the FIFO was empty.
REQ-024 A pop SHALL occur when out_valid && out_ready. instr and err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 Simultaneous push and pop at occupancy 1 SHALL leave occupancy 1, with the new entry at the head next cycle.
REQ-026 Simultaneous push and pop at occupancy 2 is impossible because in_ready=0; a pop alone SHALL reduce occupancy to 1, and in_ready SHALL be 1 the next cycle.
REQ-027 FIFO entries SHALL be delivered strictly in acceptance order; read and write pointers are 1 bit and wrap.
REQ-028 enc_count SHALL increment by 1 on every push, including error pushes.
REQ-029 err_count SHALL increment by 1 on every push with err=1 and SHALL hold at 0xFF.
REQ-030 With out_valid=0, instr and err SHALL read 0.

Reset
REQ-031 Asserting rst SHALL immediately clear occupancy, both pointers, enc_count and err_count.
REQ-032 During reset SHALL: out_valid=0, instr=0, err=0, in_ready=1.
REQ-033 rst asserted mid-transfer SHALL discard all buffered entries; no entry accepted before reset SHALL appear after it.
REQ-034 The first push SHALL be accepted at the first rising edge after rst deasserts.

Verification
REQ-035 Push `ALU_AND` rs=1 rt=2 rd=3, out_ready=1 -> next cycle instr=0x00221824, err=0, enc_count=1.
REQ-036 Push `ALU_ORI` rs=1 rt=2 imm=0x1234, then `ALU_LUI` rt=5 imm=0xABCD back-to-back -> 0x34221234 then 0x3C05ABCD in order.
REQ-037 out_ready=0, push `ALU_SLL` rt=2 rd=3 sa=4 and then `ALU_SRAV` rs=1 rt=2 rd=3 -> in_ready=0 after the second push, head held at 0x00021900; release out_ready -> 0x00221807 follows.
REQ-038 Push `ALU_DONOTHING` -> instr=0x00000000, err=1, err_count=1; 300 error pushes -> err_count=0xFF.
REQ-039 Fill the FIFO to 2, assert rst asynchronously mid-cycle -> out_valid=0, in_ready=1 and both counters 0 before the next edge; no stale entry after release.
REQ-040 Random stream of 10^4 mixed requests with random out_ready -> every output matches the reference-model encoding in order, and enc_count equals the push count mod 2^16.
